// File: rtl/rotate_sequencer.sv
// rotate_sequencer
// Multi-distance rotate controller built from the 1-bit rotate primitive.
// A request is normalised to the shorter way around the word, then one
// single-bit rotate is applied per clock until the step counter expires.
// The result is handed off through a valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a request; start_ready high
// ST_ROTATE | one rotate step per clock, step counter counting down
// ST_DONE   | result_q holds the rotated word; waiting for result_ready
module rotate_sequencer #(
    parameter int WIDTH = 20,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic             dir,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    // Shortest path is at most WIDTH/2 steps, so four bits covers 0..10.
    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROTATE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] HALF_A  = AMT_W'(WIDTH / 2);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_step;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_tc;
    logic             dir_q;

    logic             accept;
    logic [AMT_W-1:0] amt_mod;
    logic [CNT_W-1:0] steps_load;
    logic             dir_load;
    logic             steps_zero;

    assign accept     = start_valid && (state == ST_IDLE);
    assign steps_zero = (steps_load == '0);

    // Fold the requested distance into 0..WIDTH-1, then take the short way round.
    // Exactly half a turn keeps the requested direction.
    always_comb begin
        amt_mod    = amount;
        steps_load = '0;
        dir_load   = dir;
        if (amount >= WIDTH_A) begin
            amt_mod = amount - WIDTH_A;
        end
        if (amt_mod > HALF_A) begin
            steps_load = CNT_W'(WIDTH_A - amt_mod);
            dir_load   = ~dir;
        end else begin
            steps_load = CNT_W'(amt_mod);
            dir_load   = dir;
        end
    end

    // One-bit rotate of the working word in the latched effective direction.
    always_comb begin
        work_step = work_q;
        if (dir_q) begin
            work_step = {work_q[0], work_q[WIDTH-1:1]};
        end else begin
            work_step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        end
    end

    // Terminal count: the step being applied this cycle is the last one.
    assign cnt_tc = (cnt_q == CNT_W'(1));

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = steps_zero ? ST_DONE : ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                if (cnt_tc) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Working word, down-counter and result register.
    // result_q is written only on the way into ST_DONE, so it stays frozen
    // under backpressure and keeps its last value after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        work_q <= data_in;
                        cnt_q  <= steps_load;
                        dir_q  <= dir_load;
                        if (steps_zero) begin
                            result_q <= data_in;
                        end
                    end
                end
                ST_ROTATE: begin
                    work_q <= work_step;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_tc) begin
                        result_q <= work_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and status outputs decoded straight from the state register.
    assign start_ready  = (state == ST_IDLE);
    assign result_valid = (state == ST_DONE);
    assign busy         = (state == ST_ROTATE) || (state == ST_DONE);
    assign result       = result_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Scoreboard bench for rotate_sequencer: the driver pushes the hand-computed
// word and the edge on which result_valid must first appear; the monitor
// compares when the DUT presents a result and pops on the handshake.
module tb_rotate_sequencer;

    localparam int WIDTH = 20;
    localparam int AMT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] data_in;
    logic [AMT_W-1:0] amount;
    logic             dir;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    rotate_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .data_in      (data_in),
        .amount       (amount),
        .dir          (dir),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               edge_n;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (edge %0d)", name, act, req, cyc);
    endtask

    // Monitor: first cycle of result_valid checks data and latency, later
    // cycles check that the presented result is held stable.
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] held = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else if (result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else if (!prev_valid) begin
                check("result_data", 32'(result), 32'(sb[0].data));
                check("result_latency", 32'(cyc), 32'(sb[0].edge_n));
                held = result;
            end else begin
                check("hold_result", 32'(result), 32'(held));
                check("hold_busy", 32'(busy), 32'd1);
            end
            if (result_ready && sb.size() > 0) void'(sb.pop_front());
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Issue one request; exp and steps are hand-computed by the caller.
    task automatic run_op(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                          input logic dr, input logic [WIDTH-1:0] exp, input int steps);
        exp_t e;
        int   guard = 0;
        while (!start_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!start_ready) check("start_ready_timeout", 32'd0, 32'd1);
        start_valid = 1'b1;
        data_in     = d;
        amount      = a;
        dir         = dr;
        @(posedge clk); #1;
        e.data   = exp;
        e.edge_n = cyc + steps;
        sb.push_back(e);
        start_valid = 1'b0;
        data_in     = '1;
        amount      = '1;
        dir         = ~dr;
    endtask

    // Wait for the scoreboard to drain, then confirm the block is ready again
    // on the cycle after the handshake.
    task automatic wait_done();
        int guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            check("result_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end else begin
            check("ready_after_hs", 32'(start_ready), 32'd1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start_valid  = 1'b0;
        data_in      = '0;
        amount       = '0;
        dir          = 1'b0;
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_start_ready", 32'(start_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        @(posedge clk); #1;

        run_op(20'h00001, 5'd1,  1'b0, 20'h00002, 1);  wait_done();
        run_op(20'h80000, 5'd1,  1'b0, 20'h00001, 1);  wait_done();
        run_op(20'h00001, 5'd3,  1'b1, 20'h20000, 3);  wait_done();
        run_op(20'h00001, 5'd15, 1'b0, 20'h08000, 5);  wait_done();
        run_op(20'h00001, 5'd25, 1'b0, 20'h00020, 5);  wait_done();
        run_op(20'h00001, 5'd10, 1'b0, 20'h00400, 10); wait_done();
        run_op(20'h00001, 5'd31, 1'b0, 20'h00800, 9);  wait_done();
        run_op(20'h00001, 5'd12, 1'b1, 20'h00100, 8);  wait_done();
        run_op(20'hABCDE, 5'd0,  1'b0, 20'hABCDE, 0);  wait_done();
        run_op(20'hABCDE, 5'd20, 1'b1, 20'hABCDE, 0);  wait_done();

        // Backpressure with stray requests during ROTATE and DONE.
        result_ready = 1'b0;
        run_op(20'h12345, 5'd2, 1'b0, 20'h48D14, 2);
        start_valid = 1'b1;
        data_in     = 20'h0F0F0;
        amount      = 5'd4;
        dir         = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("ready_while_busy", 32'(start_ready), 32'd0);
            @(posedge clk); #1;
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        wait_done();
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a left-9 rotate.
        run_op(20'h00001, 5'd9, 1'b0, 20'h00200, 9);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(result_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_ready", 32'(start_ready), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        run_op(20'h00001, 5'd9, 1'b0, 20'h00200, 9);
        wait_done();
        repeat (4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
